// File: rtl/count_arbiter.sv
// Round-robin arbiter giving a Wishbone slave port and a logic-analyzer load port
// shared access to an external count register; free-run increments yield to loads.
module count_arbiter #(
  parameter int BITS = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_req_i,
  input  logic [BITS-1:0] la_data_i,
  output logic            la_gnt_o,
  input  logic            inc_en_i,
  input  logic [BITS-1:0] count_i,
  output logic            cnt_load_o,
  output logic [BITS-1:0] cnt_mask_o,
  output logic [BITS-1:0] cnt_data_o,
  output logic            cnt_inc_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WB = 2'd1,
    GNT_LA = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_wb_q, last_wb_d;
  logic [BITS-1:0] rdat_q, rdat_d;
  logic [BITS-1:0] sel_mask;
  logic            wb_req;

  assign wb_req = wbs_cyc_i & wbs_stb_i;

  for (genvar g = 0; g < BITS / 8; g++) begin : g_sel
    assign sel_mask[8*g +: 8] = {8{wbs_sel_i[g]}};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      last_wb_q <= 1'b0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_wb_q <= last_wb_d;
      rdat_q    <= rdat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_wb_d  = last_wb_q;
    rdat_d     = rdat_q;
    wbs_ack_o  = 1'b0;
    la_gnt_o   = 1'b0;
    cnt_load_o = 1'b0;
    cnt_mask_o = '0;
    cnt_data_o = '0;
    case (state_q)
      IDLE: begin
        // last_wb only moves on a tie, so a lone request never steals the next tie
        if (wb_req && la_req_i) begin
          if (last_wb_q) begin
            state_d   = GNT_LA;
            last_wb_d = 1'b0;
          end else begin
            state_d   = GNT_WB;
            last_wb_d = 1'b1;
          end
        end else if (wb_req) begin
          state_d = GNT_WB;
        end else if (la_req_i) begin
          state_d = GNT_LA;
        end
      end
      GNT_WB: begin
        cnt_mask_o = sel_mask;
        cnt_data_o = wbs_dat_i[BITS-1:0];
        cnt_load_o = wb_req & wbs_we_i & (|wbs_sel_i);
        rdat_d     = count_i;
        state_d    = wb_req ? ACK : IDLE;
      end
      GNT_LA: begin
        la_gnt_o   = 1'b1;
        cnt_load_o = 1'b1;
        cnt_mask_o = '1;
        cnt_data_o = la_data_i;
        state_d    = IDLE;
      end
      ACK: begin
        wbs_ack_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset too, since inc_en_i alone would otherwise leak through during reset
  assign cnt_inc_o = inc_en_i & ~cnt_load_o & ~wb_rst_i;
  assign wbs_dat_o = 32'(rdat_q);

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter: stimulus tasks queue expected output events,
// a negedge monitor pops and compares them whenever the DUT drives a strobe.
module tb_count_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_req_i;
  logic [31:0] la_data_i;
  logic        la_gnt_o;
  logic        inc_en_i;
  logic [31:0] count_i;
  logic        cnt_load_o;
  logic [31:0] cnt_mask_o;
  logic [31:0] cnt_data_o;
  logic        cnt_inc_o;

  count_arbiter #(.BITS(32)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .la_req_i  (la_req_i),
    .la_data_i (la_data_i),
    .la_gnt_o  (la_gnt_o),
    .inc_en_i  (inc_en_i),
    .count_i   (count_i),
    .cnt_load_o(cnt_load_o),
    .cnt_mask_o(cnt_mask_o),
    .cnt_data_o(cnt_data_o),
    .cnt_inc_o (cnt_inc_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    int          cyc;
    logic        load;
    logic        ack;
    logic        gnt;
    logic [31:0] mask;
    logic [31:0] data;
    logic [31:0] rdat;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc_cnt;

  // cycle 0 is the first cycle after reset release
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cyc_cnt <= 0;
    else          cyc_cnt <= cyc_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)", nm, act, exp, $time, cyc_cnt);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic push(input int c, input logic ld, input logic ak, input logic gn,
                      input logic [31:0] m, input logic [31:0] d, input logic [31:0] r);
    ev_t e;
    e.cyc = c; e.load = ld; e.ack = ak; e.gnt = gn;
    e.mask = m; e.data = d; e.rdat = r;
    exp_q.push_back(e);
  endtask

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (cnt_load_o || wbs_ack_o || la_gnt_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {29'd0, cnt_load_o, wbs_ack_o, la_gnt_o}, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_cycle", 32'(cyc_cnt), 32'(e.cyc));
          chk("event_strobes", {29'd0, cnt_load_o, wbs_ack_o, la_gnt_o},
              {29'd0, e.load, e.ack, e.gnt});
          if (e.load) begin
            chk("load_mask", cnt_mask_o, e.mask);
            chk("load_data", cnt_data_o, e.data);
            chk("inc_suppressed", {31'd0, cnt_inc_o}, 32'd0);
          end else begin
            chk("inc_no_load", {31'd0, cnt_inc_o}, {31'd0, inc_en_i});
          end
          if (e.ack) chk("read_data", wbs_dat_o, e.rdat);
        end
      end else begin
        chk("inc_idle", {31'd0, cnt_inc_o}, {31'd0, inc_en_i});
      end
    end
  end

  // One Wishbone transfer from IDLE; count_i changes during ACK to prove it was registered
  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] dat,
                         input logic [31:0] cnt, input logic [31:0] exp_mask);
    int n;
    n = cyc_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_dat_i = dat; count_i = cnt;
    if (we && sel != 4'd0) push(n + 1, 1'b1, 1'b0, 1'b0, exp_mask, dat, 32'd0);
    push(n + 2, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, cnt);
    tick(2);
    count_i = ~cnt;
    tick(1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  // Request held across several grants; a new value is presented after each grant
  task automatic la_burst(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    int n;
    logic [31:0] dv [3];
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    n = cyc_cnt;
    la_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      la_data_i = dv[i];
      push(n + 1 + 2 * i, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, dv[i], 32'd0);
      tick(2);
    end
    la_req_i = 1'b0;
  endtask

  initial begin
    int n;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'd0; wbs_dat_i = 32'd0;
    la_req_i = 1'b0; la_data_i = 32'd0;
    inc_en_i = 1'b1; count_i = 32'd0;
    tick(2);
    chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("rst_gnt", {31'd0, la_gnt_o}, 32'd0);
    chk("rst_load", {31'd0, cnt_load_o}, 32'd0);
    chk("rst_inc", {31'd0, cnt_inc_o}, 32'd0);
    chk("rst_mask", cnt_mask_o, 32'd0);
    chk("rst_data", cnt_data_o, 32'd0);
    chk("rst_rdat", wbs_dat_o, 32'd0);

    // Simultaneous requests right after reset: WB first, LA granted in cycle 4
    wb_rst_i = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_dat_i = 32'hCAFE_F00D; count_i = 32'h1111_1111;
    la_req_i = 1'b1; la_data_i = 32'h0BAD_BEEF;
    push(1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'd0);
    push(2, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h1111_1111);
    push(4, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_BEEF, 32'd0);
    tick(3);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick(2);
    la_req_i = 1'b0;
    tick(1);

    // Second tie: LA wins, WB read follows
    n = cyc_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; count_i = 32'h2222_2222;
    la_req_i = 1'b1; la_data_i = 32'h5A5A_5A5A;
    push(n + 1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 32'd0);
    push(n + 4, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h2222_2222);
    tick(2);
    la_req_i = 1'b0;
    tick(3);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick(1);

    wb_xfer(1'b1, 4'b0011, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_FFFF);
    chk("rdat_hold", wbs_dat_o, 32'hAAAA_AAAA);
    tick(1);
    wb_xfer(1'b1, 4'b1010, 32'h89AB_CDEF, 32'h0F0F_0F0F, 32'hFF00_FF00);
    tick(1);
    wb_xfer(1'b1, 4'b0000, 32'h3333_3333, 32'h4444_4444, 32'd0);
    tick(1);
    wb_xfer(1'b0, 4'hF, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'd0);
    tick(1);

    la_burst(32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFE);
    tick(1);
    inc_en_i = 1'b0;
    la_burst(32'hA5A5_0000, 32'h0000_A5A5, 32'hFFFF_FFFF);
    tick(2);
    inc_en_i = 1'b1;

    // LA request withdrawn before any edge samples it
    la_req_i = 1'b1; la_data_i = 32'h9999_9999;
    #2 la_req_i = 1'b0;
    tick(3);

    // WB strobe dropped during GNT_WB; LA request proves FSM is back in IDLE
    n = cyc_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_dat_i = 32'h5555_5555;
    tick(1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick(1);
    la_req_i = 1'b1; la_data_i = 32'h600D_F00D;
    push(n + 3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h600D_F00D, 32'd0);
    tick(2);
    la_req_i = 1'b0;
    tick(2);

    // Reset pulsed while in ACK
    n = cyc_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_dat_i = 32'h7777_7777; count_i = 32'h8888_8888;
    push(n + 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h7777_7777, 32'd0);
    tick(2);
    wb_rst_i = 1'b1;
    #1;
    chk("rst_in_ack_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("rst_in_ack_load", {31'd0, cnt_load_o}, 32'd0);
    chk("rst_in_ack_rdat", wbs_dat_o, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick(2);
    wb_rst_i = 1'b0;
    tick(5);

    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
